// File: rtl/global_pkg.sv
// Project-wide boolean constants shared by all blocks.
package global_pkg;
  localparam bit TRUE  = 1'b1;
  localparam bit FALSE = 1'b0;
endpackage

// File: rtl/uart_pkg.sv
// UART transmit types: sequencer states, tx_mux select encodings, default bit timing.
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic [1:0] SEL_IDLE   = 2'b00;
  localparam logic [1:0] SEL_START  = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  // 50 MHz system clock at 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Producer-facing bus of the UART transmit sequencer, including the tx_mux controls.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic [1:0]            sel;
  logic                  data_bit;
  logic                  parity_bit;
  logic                  busy;
  logic                  done;

  modport master (
    output start, data_in,
    input  sel, data_bit, parity_bit, busy, done
  );

  modport slave (
    input  start, data_in,
    output sel, data_bit, parity_bit, busy, done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: runs 0..CLKS_PER_BIT-1 while enabled, tick marks the last cycle of a bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int              CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames a captured word as start/data/parity/stop and steers tx_mux.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_EN    = global_pkg::TRUE,
  parameter bit PARITY_ODD   = global_pkg::FALSE
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);
  localparam int             BW       = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_e             state, next_state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BW-1:0]         bit_cnt;
  logic                  parity_q;
  logic                  done_q;
  logic                  tick;
  logic                  accept;
  logic [1:0]            sel;

  assign accept = (state == ST_IDLE) && bus.start;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state != ST_IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    sel        = SEL_IDLE;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) next_state = ST_START;
      end
      ST_START: begin
        sel = SEL_START;
        if (tick) next_state = ST_DATA;
      end
      ST_DATA: begin
        sel = SEL_DATA;
        if (tick && (bit_cnt == LAST_BIT)) next_state = PARITY_EN ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        sel = SEL_PARITY;
        if (tick) next_state = ST_STOP;
      end
      ST_STOP: begin
        if (tick) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Word, parity and counters are captured only on the accepting edge; later data_in changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == ST_STOP) && tick;
      if (accept) begin
        shift_q  <= bus.data_in;
        parity_q <= PARITY_ODD ? ~^bus.data_in : ^bus.data_in;
        bit_cnt  <= '0;
      end else if ((state == ST_DATA) && tick) begin
        shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign bus.sel        = sel;
  assign bus.data_bit   = shift_q[0];
  assign bus.parity_bit = parity_q;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: three parity configurations, frames checked cycle by cycle on the line.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int CPB = 4;

  typedef struct {
    int          dut;
    logic [63:0] line;
    int          len;
    int          n11;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus_e ();
  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus_o ();
  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus_n ();

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    dut_e (.clk(clk), .rst(rst), .bus(bus_e));
  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
    dut_o (.clk(clk), .rst(rst), .bus(bus_o));
  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  logic [1:0] m_sel  [3];
  logic       m_dbit [3];
  logic       m_pbit [3];
  logic       m_busy [3];
  logic       m_done [3];

  assign m_sel[0] = bus_e.sel;  assign m_dbit[0] = bus_e.data_bit; assign m_pbit[0] = bus_e.parity_bit;
  assign m_busy[0] = bus_e.busy; assign m_done[0] = bus_e.done;
  assign m_sel[1] = bus_o.sel;  assign m_dbit[1] = bus_o.data_bit; assign m_pbit[1] = bus_o.parity_bit;
  assign m_busy[1] = bus_o.busy; assign m_done[1] = bus_o.done;
  assign m_sel[2] = bus_n.sel;  assign m_dbit[2] = bus_n.data_bit; assign m_pbit[2] = bus_n.parity_bit;
  assign m_busy[2] = bus_n.busy; assign m_done[2] = bus_n.done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected serial line: frame bits listed first-sent at bit 0, each held for CPB cycles.
  function automatic logic [63:0] expand(input logic [15:0] bits, input int nbits);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < nbits; k++)
      for (int j = 0; j < CPB; j++)
        v[k*CPB+j] = bits[k];
    return v;
  endfunction

  task automatic push(input int dut, input logic [15:0] bits, input int nbits, input int gap);
    exp_t e;
    e.dut  = dut;
    e.line = expand(bits, nbits);
    e.len  = nbits * CPB;
    e.n11  = (nbits == 11) ? CPB : 0;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int idx, input logic s, input logic [7:0] d);
    case (idx)
      0: begin bus_e.start = s; bus_e.data_in = d; end
      1: begin bus_o.start = s; bus_o.data_in = d; end
      default: begin bus_n.start = s; bus_n.data_in = d; end
    endcase
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    drive(idx, 1'b1, d);
    @(negedge clk);
    drive(idx, 1'b0, d);
  endtask

  task automatic wait_done(input int idx);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (m_done[idx] === 1'b1) return;
    end
    tests++;
    fails++;
    $display("FAIL done_timeout: dut %0d no done within 600 cycles", idx);
  endtask

  // Monitor: rebuilds each frame from the line level and scores it when done pulses.
  int          cyc = 0;
  bit          in_frame  [3];
  int          n         [3];
  int          n11       [3];
  int          rise_cyc  [3];
  int          last_done [3];
  logic [63:0] got       [3];

  always @(negedge clk) begin
    exp_t e;
    logic lvl;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst !== 1'b1) begin
        in_frame[i] = 1'b0;
      end else if (m_busy[i] === 1'b1) begin
        if (!in_frame[i]) begin
          in_frame[i] = 1'b1;
          n[i]        = 0;
          n11[i]      = 0;
          got[i]      = '0;
          rise_cyc[i] = cyc;
          check("start_sel", 64'(m_sel[i]), 64'(SEL_START));
        end
        case (m_sel[i])
          SEL_IDLE:  lvl = 1'b1;
          SEL_START: lvl = 1'b0;
          SEL_DATA:  lvl = m_dbit[i];
          default:   lvl = m_pbit[i];
        endcase
        if (n[i] < 64) got[i][n[i]] = lvl;
        if (m_sel[i] == SEL_PARITY) n11[i]++;
        n[i]++;
      end else if (m_done[i] === 1'b1) begin
        if (!in_frame[i] || exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: dut %0d at cycle %0d", i, cyc);
        end else begin
          e = exp_q.pop_front();
          check("frame_dut", 64'(i), 64'(e.dut));
          check("frame_len", 64'(n[i]), 64'(e.len));
          check("frame_line", got[i], e.line);
          check("parity_cycles", 64'(n11[i]), 64'(e.n11));
          if (e.gap >= 0) check("b2b_gap", 64'(rise_cyc[i] - last_done[i]), 64'(e.gap));
        end
        in_frame[i]  = 1'b0;
        last_done[i] = cyc;
      end else if (in_frame[i]) begin
        tests++;
        fails++;
        $display("FAIL busy_drop: dut %0d busy fell without done at cycle %0d", i, cyc);
        in_frame[i] = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    drive(0, 1'b1, 8'hA5);

    // Reset with start held: nothing may begin.
    repeat (3) @(negedge clk);
    check("rst_sel", 64'(bus_e.sel), 64'(SEL_IDLE));
    check("rst_busy", 64'(bus_e.busy), 64'd0);
    check("rst_done", 64'(bus_e.done), 64'd0);
    check("rst_data_bit", 64'(bus_e.data_bit), 64'd0);
    check("rst_parity_bit", 64'(bus_e.parity_bit), 64'd0);

    // A5 even: start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1.
    push(0, 16'b10101001010, 11, -1);
    rst = 1'b1;
    @(negedge clk);
    check("accept_busy", 64'(bus_e.busy), 64'd1);
    drive(0, 1'b0, 8'hA5);
    wait_done(0);

    // Odd parity: 07 -> 0, 03 -> 1.
    push(1, 16'b10000001110, 11, -1);
    send(1, 8'h07);
    wait_done(1);
    push(1, 16'b11000000110, 11, -1);
    send(1, 8'h03);
    wait_done(1);

    // No parity: 10-bit frame, done at cycle 41.
    push(2, 16'b1100101100, 10, -1);
    send(2, 8'h96);
    wait_done(2);

    // Start with 3C at cycle 10 of a 5A frame is ignored.
    push(0, 16'b10010110100, 11, -1);
    send(0, 8'h5A);
    repeat (9) @(negedge clk);
    drive(0, 1'b1, 8'h3C);
    @(negedge clk);
    drive(0, 1'b0, 8'h3C);
    wait_done(0);

    // Start held high: second frame starts the cycle after done.
    push(0, 16'b10010101010, 11, -1);
    push(0, 16'b10010101010, 11, 1);
    drive(0, 1'b1, 8'h55);
    wait_done(0);
    @(negedge clk);
    drive(0, 1'b0, 8'h55);
    wait_done(0);

    // Reset during DATA bit 3 (cycles 17..20).
    send(0, 8'hFF);
    repeat (17) @(negedge clk);
    check("pre_rst_sel", 64'(bus_e.sel), 64'(SEL_DATA));
    #1 rst = 1'b0;
    #1;
    check("mid_rst_sel", 64'(bus_e.sel), 64'(SEL_IDLE));
    check("mid_rst_busy", 64'(bus_e.busy), 64'd0);
    check("mid_rst_done", 64'(bus_e.done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_rst_idle", 64'({bus_e.sel, bus_e.busy}), 64'd0);
    end

    // Recovery frame after the aborted one.
    push(0, 16'b10100000010, 11, -1);
    send(0, 8'h81);
    wait_done(0);

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
